// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one data-memory port between the CPU data port and
// the FPGA I/O front end. One owner at a time, round-robin on ties, each
// transfer held until mem_ack or aborted by a wait-cycle timeout.
//
// Handshake: a requester raises x_req with stable we/addr/wdata and holds it
// until it sees a one-cycle x_ack pulse; x_rdata is valid in that ack cycle.
// Towards memory, mem_en stays high with stable we/addr/wdata until the cycle
// in which mem_ack is sampled high (mem_rdata is valid in that same cycle).
module mem_bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    input  logic              fpga_req,
    input  logic              fpga_we,
    input  logic [ADDR_W-1:0] fpga_addr,
    input  logic [DATA_W-1:0] fpga_wdata,
    output logic [DATA_W-1:0] fpga_rdata,
    output logic              fpga_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        owner,
    output logic              timeout_err,
    output logic [1:0]        dbg_state
);

    // State encoding doubles as the owner code (00 none, 01 CPU, 10 FPGA).
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        CPU_BUSY  = 2'b01,
        FPGA_BUSY = 2'b10
    } state_t;

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic              last_fpga_q;   // 1 = FPGA held the previous grant
    logic              lat_we_q;
    logic [ADDR_W-1:0] lat_addr_q;
    logic [DATA_W-1:0] lat_wdata_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic              cpu_ack_q, fpga_ack_q;
    logic [DATA_W-1:0] cpu_rdata_q, fpga_rdata_q;
    logic              timeout_q;

    logic cpu_req_m, fpga_req_m;
    logic grant_cpu, grant_fpga;
    logic busy, timed_out, done;

    // Arbitration and next-state: requests are masked during their own ack cycle.
    always_comb begin
        grant_cpu  = 1'b0;
        grant_fpga = 1'b0;
        state_d    = state_q;
        cpu_req_m  = cpu_req & ~cpu_ack_q;
        fpga_req_m = fpga_req & ~fpga_ack_q;
        busy       = (state_q != IDLE);
        timed_out  = busy & ~mem_ack & (wait_cnt_q == CNT_LAST);
        done       = busy & (mem_ack | timed_out);
        case (state_q)
            IDLE: begin
                if (cpu_req_m && fpga_req_m) begin
                    grant_cpu  = last_fpga_q;
                    grant_fpga = ~last_fpga_q;
                end else begin
                    grant_cpu  = cpu_req_m;
                    grant_fpga = fpga_req_m;
                end
                if (grant_cpu)
                    state_d = CPU_BUSY;
                else if (grant_fpga)
                    state_d = FPGA_BUSY;
            end
            CPU_BUSY, FPGA_BUSY: begin
                if (done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Grant bookkeeping: latch the winner's transfer and track round-robin history.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            last_fpga_q <= 1'b0;
            lat_we_q    <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
        end else if (grant_cpu) begin
            last_fpga_q <= 1'b0;
            lat_we_q    <= cpu_we;
            lat_addr_q  <= cpu_addr;
            lat_wdata_q <= cpu_wdata;
        end else if (grant_fpga) begin
            last_fpga_q <= 1'b1;
            lat_we_q    <= fpga_we;
            lat_addr_q  <= fpga_addr;
            lat_wdata_q <= fpga_wdata;
        end
    end

    // Wait counter: cleared on grant, counts BUSY cycles without mem_ack.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            wait_cnt_q <= '0;
        else if (grant_cpu || grant_fpga)
            wait_cnt_q <= '0;
        else if (busy && !done)
            wait_cnt_q <= wait_cnt_q + 1'b1;
    end

    // Completion: one-cycle ack to the owner, read data or all-ones on timeout.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cpu_ack_q    <= 1'b0;
            fpga_ack_q   <= 1'b0;
            cpu_rdata_q  <= '0;
            fpga_rdata_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            cpu_ack_q  <= done & (state_q == CPU_BUSY);
            fpga_ack_q <= done & (state_q == FPGA_BUSY);
            if (timed_out)
                timeout_q <= 1'b1;
            if (done && state_q == CPU_BUSY) begin
                if (timed_out)
                    cpu_rdata_q <= {DATA_W{1'b1}};
                else if (!lat_we_q)
                    cpu_rdata_q <= mem_rdata;
            end
            if (done && state_q == FPGA_BUSY) begin
                if (timed_out)
                    fpga_rdata_q <= {DATA_W{1'b1}};
                else if (!lat_we_q)
                    fpga_rdata_q <= mem_rdata;
            end
        end
    end

    // Memory side is quiet outside a grant so idle cycles drive all zeros.
    always_comb begin
        mem_en      = busy;
        mem_we      = busy & lat_we_q;
        mem_addr    = busy ? lat_addr_q  : '0;
        mem_wdata   = busy ? lat_wdata_q : '0;
        owner       = state_q;
        dbg_state   = state_q;
        cpu_ack     = cpu_ack_q;
        fpga_ack    = fpga_ack_q;
        cpu_rdata   = cpu_rdata_q;
        fpga_rdata  = fpga_rdata_q;
        timeout_err = timeout_q;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. Inputs change and outputs are
// checked on the falling clock edge, away from the sampling edge.
module tb_mem_bus_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk;
    logic              nrst;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              cpu_ack;
    logic              fpga_req, fpga_we;
    logic [ADDR_W-1:0] fpga_addr;
    logic [DATA_W-1:0] fpga_wdata, fpga_rdata;
    logic              fpga_ack;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_ack;
    logic [1:0]        owner;
    logic              timeout_err;
    logic [1:0]        dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nrst(nrst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .fpga_req(fpga_req), .fpga_we(fpga_we), .fpga_addr(fpga_addr),
        .fpga_wdata(fpga_wdata), .fpga_rdata(fpga_rdata), .fpga_ack(fpga_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .owner(owner), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mem_en"},      64'(mem_en),      64'd0);
        chk({tag, ".mem_we"},      64'(mem_we),      64'd0);
        chk({tag, ".mem_addr"},    64'(mem_addr),    64'd0);
        chk({tag, ".mem_wdata"},   64'(mem_wdata),   64'd0);
        chk({tag, ".cpu_ack"},     64'(cpu_ack),     64'd0);
        chk({tag, ".fpga_ack"},    64'(fpga_ack),    64'd0);
        chk({tag, ".cpu_rdata"},   64'(cpu_rdata),   64'd0);
        chk({tag, ".fpga_rdata"},  64'(fpga_rdata),  64'd0);
        chk({tag, ".owner"},       64'(owner),       64'd0);
        chk({tag, ".timeout_err"}, 64'(timeout_err), 64'd0);
        chk({tag, ".dbg_state"},   64'(dbg_state),   64'd0);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        step();
        step();
        nrst = 1'b1;
        step();
    endtask

    initial begin
        nrst = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
        fpga_req = 0; fpga_we = 0; fpga_addr = '0; fpga_wdata = '0;
        mem_rdata = '0; mem_ack = 0;
        step();
        chk_all_zero("rst0");
        nrst = 1'b1;
        step();

        // T2: single CPU read at 280, mem_ack in the third BUSY cycle.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'd280;
        step();
        chk("t2.owner_b1", 64'(owner), 64'h1);
        chk("t2.mem_en_b1", 64'(mem_en), 64'h1);
        chk("t2.addr_b1", 64'(mem_addr), 64'd280);
        chk("t2.we_b1", 64'(mem_we), 64'h0);
        chk("t2.ack_b1", 64'(cpu_ack), 64'h0);
        step();
        chk("t2.mem_en_b2", 64'(mem_en), 64'h1);
        chk("t2.we_b2", 64'(mem_we), 64'h0);
        step();
        chk("t2.mem_en_b3", 64'(mem_en), 64'h1);
        mem_ack = 1; mem_rdata = 32'h2A;
        step();
        mem_ack = 0; mem_rdata = 32'hDEAD;
        chk("t2.cpu_ack", 64'(cpu_ack), 64'h1);
        chk("t2.cpu_rdata", 64'(cpu_rdata), 64'h2A);
        chk("t2.fpga_ack", 64'(fpga_ack), 64'h0);
        chk("t2.owner_ack", 64'(owner), 64'h0);
        chk("t2.mem_en_ack", 64'(mem_en), 64'h0);
        cpu_req = 0;
        step();
        chk("t2.ack_pulse", 64'(cpu_ack), 64'h0);
        chk("t2.rdata_hold", 64'(cpu_rdata), 64'h2A);
        chk("t2.owner_idle", 64'(owner), 64'h0);

        // T3: tie from reset, FPGA wins first, then alternate.
        do_reset();
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h100; cpu_wdata = 32'h22;
        fpga_req = 1; fpga_we = 1; fpga_addr = 32'd220; fpga_wdata = 32'h11;
        step();
        chk("t3.owner1", 64'(owner), 64'h2);
        chk("t3.addr1", 64'(mem_addr), 64'd220);
        chk("t3.we1", 64'(mem_we), 64'h1);
        chk("t3.wdata1", 64'(mem_wdata), 64'h11);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("t3.fpga_ack1", 64'(fpga_ack), 64'h1);
        chk("t3.cpu_ack1", 64'(cpu_ack), 64'h0);
        chk("t3.owner_ack1", 64'(owner), 64'h0);
        chk("t3.fpga_rdata_wr", 64'(fpga_rdata), 64'h0);
        fpga_addr = 32'd240; fpga_wdata = 32'h33;
        step();
        chk("t3.owner2", 64'(owner), 64'h1);
        chk("t3.addr2", 64'(mem_addr), 64'h100);
        chk("t3.wdata2", 64'(mem_wdata), 64'h22);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("t3.cpu_ack2", 64'(cpu_ack), 64'h1);
        chk("t3.fpga_ack2", 64'(fpga_ack), 64'h0);
        step();
        chk("t3.owner3", 64'(owner), 64'h2);
        chk("t3.addr3", 64'(mem_addr), 64'd240);
        chk("t3.wdata3", 64'(mem_wdata), 64'h33);
        mem_ack = 1;
        step();
        mem_ack = 0;
        chk("t3.fpga_ack3", 64'(fpga_ack), 64'h1);
        cpu_req = 0; fpga_req = 0;
        step();
        // Fresh tie after an FPGA grant goes to the CPU.
        cpu_req = 1; fpga_req = 1;
        step();
        chk("t3.owner4_tie", 64'(owner), 64'h1);
        mem_ack = 1;
        step();
        mem_ack = 0;
        cpu_req = 0; fpga_req = 0;
        step();
        chk("t3.owner_end", 64'(owner), 64'h0);

        // T4: FPGA holds req through its ack, no regrant in the ack cycle.
        fpga_req = 1; fpga_we = 0; fpga_addr = 32'd260;
        step();
        chk("t4.owner1", 64'(owner), 64'h2);
        mem_ack = 1; mem_rdata = 32'h55;
        step();
        mem_ack = 0;
        chk("t4.fpga_ack", 64'(fpga_ack), 64'h1);
        chk("t4.fpga_rdata", 64'(fpga_rdata), 64'h55);
        chk("t4.owner_ack", 64'(owner), 64'h0);
        step();
        chk("t4.no_regrant", 64'(owner), 64'h0);
        chk("t4.ack_low", 64'(fpga_ack), 64'h0);
        step();
        chk("t4.regrant", 64'(owner), 64'h2);
        chk("t4.mem_en", 64'(mem_en), 64'h1);
        mem_ack = 1; mem_rdata = 32'h66;
        step();
        mem_ack = 0;
        fpga_req = 0;
        chk("t4.fpga_rdata2", 64'(fpga_rdata), 64'h66);
        step();

        // T6: mem_ack in BUSY cycle TIMEOUT completes normally.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'd280;
        step();
        for (int i = 1; i < TIMEOUT; i++) step();
        chk("t6.mem_en_last", 64'(mem_en), 64'h1);
        chk("t6.owner_last", 64'(owner), 64'h1);
        mem_ack = 1; mem_rdata = 32'h77;
        step();
        mem_ack = 0;
        chk("t6.cpu_ack", 64'(cpu_ack), 64'h1);
        chk("t6.cpu_rdata", 64'(cpu_rdata), 64'h77);
        chk("t6.timeout_err", 64'(timeout_err), 64'h0);
        cpu_req = 0;
        step();

        // T5: no mem_ack, abort after TIMEOUT BUSY cycles.
        cpu_req = 1; cpu_we = 0; cpu_addr = 32'd280;
        step();
        for (int i = 1; i < TIMEOUT; i++) step();
        chk("t5.mem_en_last", 64'(mem_en), 64'h1);
        chk("t5.ack_early", 64'(cpu_ack), 64'h0);
        chk("t5.err_early", 64'(timeout_err), 64'h0);
        step();
        chk("t5.cpu_ack", 64'(cpu_ack), 64'h1);
        chk("t5.cpu_rdata", 64'(cpu_rdata), 64'hFFFFFFFF);
        chk("t5.timeout_err", 64'(timeout_err), 64'h1);
        chk("t5.owner", 64'(owner), 64'h0);
        cpu_req = 0;
        step();
        step();
        chk("t5.err_sticky", 64'(timeout_err), 64'h1);

        // T1: reset during CPU_BUSY aborts with no ack.
        cpu_req = 1; cpu_we = 1; cpu_addr = 32'h44; cpu_wdata = 32'h99;
        step();
        chk("t1.busy", 64'(owner), 64'h1);
        nrst = 1'b0;
        #1;
        chk_all_zero("t1.rst");
        cpu_req = 0;
        step();
        nrst = 1'b1;
        step();
        chk("t1.no_ack", 64'(cpu_ack), 64'h0);
        chk("t1.owner", 64'(owner), 64'h0);
        step();
        chk("t1.no_ack2", 64'(cpu_ack), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
